// File: rtl/spi_alu_pkg.sv
// Shared definitions for the SPI arithmetic slave: opcode values, the frame
// FSM state encoding and the depth of the input synchronisers.
package spi_alu_pkg;

    // Opcode field values (low two bits of the opcode field).
    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    // Frame FSM states.
    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CALC,
        SEND,
        FIN
    } state_t;

    // Flops in each SCLK/CS/MOSI synchroniser; SCLK and CS carry one extra
    // flop behind these for edge detection.
    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/seq_mul.sv
// Unsigned shift-add multiplier.
// Adds the shifted multiplicand into the accumulator once per cycle, for
// WIDTH cycles after start is accepted, then pulses done for one cycle with the
// product held on product.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : load a/b and begin a multiply
//   abort   : stop immediately and clear all state
//   a, b    : WIDTH-bit unsigned operands
//   busy    : multiply in progress
//   done    : one-cycle pulse, product valid
//   product : 2*WIDTH-bit result
module seq_mul #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;

    // Sum carried at 2N+1 bits; the carry can never be set for an N x N product.
    logic [2*WIDTH:0]   acc_sum;
    logic               unused_carry;

    assign acc_sum      = {1'b0, acc_q} + {1'b0, mcand_q};
    assign unused_carry = acc_sum[2*WIDTH];

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= CNT_INIT;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_sum[2*WIDTH-1:0];
            end
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/spi_alu_slave.sv
// SPI slave arithmetic unit.
// A frame is: opcode (OPW bits), A (WIDTH bits), B (WIDTH bits) on MOSI, MSB
// first, sampled on SCLK rise; then the 2*WIDTH-bit result on MISO, MSB first,
// driven on SCLK fall. Opcodes: unsigned multiply, signed multiply, add, subtract.
// SCLK, CS and MOSI are oversampled in the CLK domain.
//   CLK  : system clock, rising edge
//   RST  : synchronous active-high reset
//   SCLK : SPI clock (asynchronous)
//   CS   : chip select, active-high (asynchronous); a fall aborts any frame
//   MOSI : serial data in
//   MISO : serial result out, 0 outside the result phase
//   BUSY : frame in progress (CS rise until last result bit sampled)
//   DONE : one-CLK pulse after the last result bit has been sampled
module spi_alu_slave
    import spi_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OPW   = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic SCLK,
    input  logic CS,
    input  logic MOSI,
    output logic MISO,
    output logic BUSY,
    output logic DONE
);

    localparam int unsigned RES_W   = 2 * WIDTH;
    localparam int unsigned FRAME_W = OPW + RES_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(RES_W - 1);

    // ---------------- synchronisers and edge detection ----------------
    logic [SYNC_DEPTH:0]   sclk_sh;
    logic [SYNC_DEPTH:0]   cs_sh;
    logic [SYNC_DEPTH-1:0] mosi_sh;

    // CS chain resets high so a CS still asserted across RST cannot look like
    // a fresh rise; the slave only restarts after CS genuinely falls and rises.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_sh <= '0;
            cs_sh   <= '1;
            mosi_sh <= '0;
        end else begin
            sclk_sh <= {sclk_sh[SYNC_DEPTH-1:0], SCLK};
            cs_sh   <= {cs_sh[SYNC_DEPTH-1:0], CS};
            mosi_sh <= {mosi_sh[SYNC_DEPTH-2:0], MOSI};
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;
    assign sclk_rise = sclk_sh[SYNC_DEPTH-1] & ~sclk_sh[SYNC_DEPTH];
    assign sclk_fall = ~sclk_sh[SYNC_DEPTH-1] & sclk_sh[SYNC_DEPTH];
    assign cs_rise   = cs_sh[SYNC_DEPTH-1] & ~cs_sh[SYNC_DEPTH];
    assign cs_fall   = ~cs_sh[SYNC_DEPTH-1] & cs_sh[SYNC_DEPTH];
    assign mosi_bit  = mosi_sh[SYNC_DEPTH-1];

    // ---------------- state ----------------
    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RES_W-1:0]    out_q, out_d;
    logic                miso_q, miso_d;
    logic                done_q, done_d;

    // ---------------- operand decode and arithmetic ----------------
    logic [OPW-1:0]   op_field;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a, op_b, mul_a, mul_b;
    logic             neg_a, neg_b, negate;

    assign op_field = shreg_q[FRAME_W-1 -: OPW];
    assign op       = op_field[1:0];
    assign op_a     = shreg_q[RES_W-1 -: WIDTH];
    assign op_b     = shreg_q[WIDTH-1:0];

    // Signed multiply runs on magnitudes; -2^(N-1) maps to 2^(N-1), which is
    // still representable as an N-bit unsigned operand.
    assign neg_a  = (op == OP_MULS) & op_a[WIDTH-1];
    assign neg_b  = (op == OP_MULS) & op_b[WIDTH-1];
    assign negate = neg_a ^ neg_b;
    assign mul_a  = neg_a ? -op_a : op_a;
    assign mul_b  = neg_b ? -op_b : op_b;

    logic               mul_start, mul_abort, mul_busy, mul_done;
    logic [RES_W-1:0]   mul_prod;

    seq_mul #(
        .WIDTH (WIDTH)
    ) u_seq_mul (
        .clk     (CLK),
        .rst     (RST),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (mul_a),
        .b       (mul_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    logic [RES_W:0] mul_ext, add_sum, sub_diff;
    logic [2:0]     unused_msbs;

    assign mul_ext  = negate ? -{1'b0, mul_prod} : {1'b0, mul_prod};
    assign add_sum  = {{(WIDTH+1){1'b0}}, op_a} + {{(WIDTH+1){1'b0}}, op_b};
    assign sub_diff = {{(WIDTH+1){op_a[WIDTH-1]}}, op_a}
                    - {{(WIDTH+1){op_b[WIDTH-1]}}, op_b};
    assign unused_msbs = {mul_ext[RES_W], add_sum[RES_W], sub_diff[RES_W]};

    // ---------------- next state / outputs ----------------
    logic in_frame;
    assign in_frame = (state_q == RECV) || (state_q == CALC) || (state_q == SEND);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        miso_d    = miso_q;
        done_d    = 1'b0;
        mul_start = 1'b0;
        mul_abort = 1'b0;

        if (in_frame && cs_fall) begin
            // Abort: CS wins over any SCLK edge seen in the same cycle.
            state_d   = IDLE;
            shreg_d   = '0;
            cnt_d     = '0;
            out_d     = '0;
            miso_d    = 1'b0;
            mul_abort = (state_q == CALC);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_rise) begin
                        cnt_d   = '0;
                        shreg_d = '0;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (sclk_rise) begin
                        shreg_d = {shreg_q[FRAME_W-2:0], mosi_bit};
                        cnt_d   = cnt_q + CNT_ONE;
                        if (cnt_q == RECV_LAST) begin
                            cnt_d   = '0;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (mul_done) begin
                        out_d   = mul_ext[RES_W-1:0];
                        miso_d  = 1'b0;
                        state_d = SEND;
                    end else if (!mul_busy) begin
                        // Load cycle: add/sub finish here, multiplies are started.
                        unique case (op)
                            OP_ADD: begin
                                out_d   = add_sum[RES_W-1:0];
                                state_d = SEND;
                            end
                            OP_SUB: begin
                                out_d   = sub_diff[RES_W-1:0];
                                state_d = SEND;
                            end
                            default: mul_start = 1'b1;
                        endcase
                    end
                end
                SEND: begin
                    if (sclk_fall) begin
                        miso_d = out_q[RES_W-1];
                        out_d  = {out_q[RES_W-2:0], 1'b0};
                    end else if (sclk_rise) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == SEND_LAST) begin
                            cnt_d   = '0;
                            miso_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = FIN;
                        end
                    end
                end
                FIN: begin
                    if (cs_fall) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            miso_q  <= miso_d;
            done_q  <= done_d;
        end
    end

    assign MISO = miso_q;
    assign BUSY = in_frame;
    assign DONE = done_q;

endmodule
